hist_equalizer: RTL and testbench

- Consumer of the cumulative histogram (CDF) produced during vertical blanking.
- Loads 256 CDF words over a valid/ready stream and normalises them into a 12-bit grey-remap LUT using a sequential divider.
- During the next frame, maps each incoming grey pixel through the LUT, so the output is the histogram-equalised grey stream.
- The LUT is double-buffered, so the mapping never sees a partially built table.

---
 rtl/hist_equalizer.sv | 237 +++++++++++++++++++++++
 tb/tb_hist_equalizer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_equalizer.sv
// hist_equalizer: normalises a streamed 256-bin CDF into a 12-bit grey-remap LUT during
// blanking and remaps the live grey stream through the active bank of a double-buffered LUT.
module hist_equalizer #(
    parameter int unsigned BINS    = 256,
    parameter int unsigned CDF_W   = 20,
    parameter int unsigned OUT_MAX = 4095
) (
    input  logic             iPclk,
    input  logic             iRST_N,
    input  logic             iFval,
    input  logic             iDval,
    input  logic [11:0]      iGrey,
    input  logic             iCdf_Valid,
    input  logic [7:0]       iCdf_Addr,
    input  logic [CDF_W-1:0] iCdf_Data,
    input  logic             iCdf_Last,
    output logic             oCdf_Ready,
    output logic [11:0]      oGrey_Eq,
    output logic             oDval,
    output logic             oFval,
    output logic             oLut_Valid,
    output logic             oLoad_Err,
    output logic [1:0]       oState
);

    localparam int unsigned Q_W   = 12;
    localparam int unsigned NUM_W = CDF_W + Q_W;

    typedef enum logic [1:0] {StIdle = 2'd0, StLoad = 2'd1, StNorm = 2'd2} state_e;

    state_e           state_q, state_d;
    logic [8:0]       cnt_q, cnt_d, cnt_inc;
    logic [CDF_W-1:0] min_q, min_d, max_q, max_d;
    logic [CDF_W-1:0] min_base, max_base, min_new, max_new;
    logic [7:0]       bin_q, bin_d;
    logic [3:0]       step_q, step_d;
    logic [CDF_W-1:0] rem_q, rem_d;
    logic [Q_W-1:0]   low_q, low_d, quo_q, quo_d;
    logic             ovf_q, ovf_d;
    logic             bank_q, bank_d, lut_valid_q, lut_valid_d, err_q, err_d;
    logic             fval_prev_q;
    logic             cdf_ready, xfer, fval_rise, abort, load_ok, load_bad, norm_done;
    logic [CDF_W-1:0] den;
    logic             den_zero;
    logic [NUM_W-1:0] num;
    logic [CDF_W:0]   trial;
    logic             lut_we;
    logic [Q_W-1:0]   lut_wdata;

    logic [CDF_W-1:0] cdf_mem [BINS];
    logic [CDF_W-1:0] cdf_rd_q;
    logic [Q_W-1:0]   lut_mem [2*BINS];
    logic [Q_W-1:0]   lut_rd_q;

    logic [11:0]      grey_d1_q, grey_eq_q, grey_eq_d;
    logic             dval_d1_q, fval_d1_q, dval_q, fval_q;

    // FSM state register
    always_ff @(posedge iPclk or negedge iRST_N) begin
        if (!iRST_N) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // FSM next state: load, normalise, abort on frame start
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (xfer) state_d = iCdf_Last ? StIdle : StLoad;
            StLoad: begin
                if (abort)                  state_d = StIdle;
                else if (xfer && iCdf_Last) state_d = load_ok ? StNorm : StIdle;
            end
            StNorm: if (abort || norm_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs and load qualification
    always_comb begin
        cdf_ready = ((state_q == StIdle) || (state_q == StLoad)) && !iFval;
        xfer      = iCdf_Valid && cdf_ready;
        fval_rise = iFval && !fval_prev_q;
        abort     = fval_rise && ((state_q == StLoad) || (state_q == StNorm));
        // The first word of a load starts from a cleared count/min/max.
        min_base  = (state_q == StIdle) ? '1 : min_q;
        max_base  = (state_q == StIdle) ? '0 : max_q;
        cnt_inc   = ((state_q == StIdle) ? 9'd0 : cnt_q) + 9'd1;
        min_new   = ((iCdf_Data != '0) && (iCdf_Data < min_base)) ? iCdf_Data : min_base;
        max_new   = (iCdf_Addr == 8'hFF) ? iCdf_Data : max_base;
        load_ok   = xfer && iCdf_Last && (state_q == StLoad) && (cnt_inc == 9'(BINS))
                    && (max_new != '0);
        load_bad  = xfer && iCdf_Last && !load_ok;
        norm_done = (state_q == StNorm) && (step_q == 4'd14) && (bin_q == 8'(BINS - 1));
        // A non-monotonic CDF (min above max) is treated like a flat one.
        den       = max_q - min_q;
        den_zero  = (max_q <= min_q);
    end

    // Datapath next state: load capture, per-bin restoring divide, LUT write and bank swap
    always_comb begin
        cnt_d       = cnt_q;
        min_d       = min_q;
        max_d       = max_q;
        bin_d       = bin_q;
        step_d      = step_q;
        rem_d       = rem_q;
        low_d       = low_q;
        quo_d       = quo_q;
        ovf_d       = ovf_q;
        bank_d      = bank_q;
        lut_valid_d = lut_valid_q;
        err_d       = load_bad;
        lut_we      = 1'b0;
        lut_wdata   = '0;
        num         = '0;
        trial       = '0;
        if (xfer) begin
            cnt_d = cnt_inc;
            min_d = min_new;
            max_d = max_new;
        end
        if (load_ok) begin
            bin_d  = '0;
            step_d = '0;
        end
        if (state_q == StNorm) begin
            step_d = step_q + 4'd1;
            if (step_q == 4'd1) begin
                // cdf_rd_q now holds this bin's count
                num   = (cdf_rd_q < min_q) ? '0
                        : NUM_W'(cdf_rd_q - min_q) * NUM_W'(OUT_MAX);
                rem_d = num[NUM_W-1:Q_W];
                low_d = num[Q_W-1:0];
                quo_d = '0;
                ovf_d = (num[NUM_W-1:Q_W] >= den);
            end else if ((step_q >= 4'd2) && (step_q <= 4'd13)) begin
                trial = {rem_q, low_q[Q_W-1]};
                if (trial >= {1'b0, den}) begin
                    rem_d = trial[CDF_W-1:0] - den;
                    quo_d = {quo_q[Q_W-2:0], 1'b1};
                end else begin
                    rem_d = trial[CDF_W-1:0];
                    quo_d = {quo_q[Q_W-2:0], 1'b0};
                end
                low_d = {low_q[Q_W-2:0], 1'b0};
            end else if (step_q == 4'd14) begin
                lut_we    = !abort;
                lut_wdata = den_zero ? {bin_q, bin_q[7:4]} : (ovf_q ? Q_W'(OUT_MAX) : quo_q);
                step_d    = '0;
                bin_d     = bin_q + 8'd1;
                if (norm_done && !abort) begin
                    bank_d      = !bank_q;
                    lut_valid_d = 1'b1;
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge iPclk or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt_q       <= '0;
            min_q       <= '0;
            max_q       <= '0;
            bin_q       <= '0;
            step_q      <= '0;
            rem_q       <= '0;
            low_q       <= '0;
            quo_q       <= '0;
            ovf_q       <= 1'b0;
            bank_q      <= 1'b0;
            lut_valid_q <= 1'b0;
            err_q       <= 1'b0;
            fval_prev_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            min_q       <= min_d;
            max_q       <= max_d;
            bin_q       <= bin_d;
            step_q      <= step_d;
            rem_q       <= rem_d;
            low_q       <= low_d;
            quo_q       <= quo_d;
            ovf_q       <= ovf_d;
            bank_q      <= bank_d;
            lut_valid_q <= lut_valid_d;
            err_q       <= err_d;
            fval_prev_q <= iFval;
        end
    end

    // CDF scratch RAM: written by the load, read registered by the normaliser
    always_ff @(posedge iPclk) begin
        if (xfer) cdf_mem[iCdf_Addr] <= iCdf_Data;
        cdf_rd_q <= cdf_mem[bin_q];
    end

    // Double-buffered LUT: normaliser writes the shadow bank, mapping reads the active bank
    always_ff @(posedge iPclk) begin
        if (lut_we) lut_mem[{!bank_q, bin_q}] <= lut_wdata;
        lut_rd_q <= lut_mem[{bank_q, iGrey[11:4]}];
    end

    // Mapping output select: LUT when built, else bypass; blank when no valid pixel
    always_comb begin
        grey_eq_d = '0;
        if (dval_d1_q) grey_eq_d = lut_valid_q ? lut_rd_q : grey_d1_q;
    end

    // Two-stage mapping pipeline
    always_ff @(posedge iPclk or negedge iRST_N) begin
        if (!iRST_N) begin
            grey_d1_q <= '0;
            dval_d1_q <= 1'b0;
            fval_d1_q <= 1'b0;
            grey_eq_q <= '0;
            dval_q    <= 1'b0;
            fval_q    <= 1'b0;
        end else begin
            grey_d1_q <= iGrey;
            dval_d1_q <= iDval;
            fval_d1_q <= iFval;
            grey_eq_q <= grey_eq_d;
            dval_q    <= dval_d1_q;
            fval_q    <= fval_d1_q;
        end
    end

    assign oCdf_Ready = cdf_ready;
    assign oGrey_Eq   = grey_eq_q;
    assign oDval      = dval_q;
    assign oFval      = fval_q;
    assign oLut_Valid = lut_valid_q;
    assign oLoad_Err  = err_q;
    assign oState     = state_q;

endmodule

// File: tb/tb_hist_equalizer.sv
// Bench for hist_equalizer: directed CDF loads and pixel frames, an arithmetic LUT model
// feeding a per-cycle output compare, plus hand-computed literal expectations.
module tb_hist_equalizer;

    logic        iPclk = 1'b0;
    logic        iRST_N;
    logic        iFval, iDval, iCdf_Valid, iCdf_Last;
    logic [11:0] iGrey;
    logic [7:0]  iCdf_Addr;
    logic [19:0] iCdf_Data;
    logic        oCdf_Ready, oDval, oFval, oLut_Valid, oLoad_Err;
    logic [11:0] oGrey_Eq;
    logic [1:0]  oState;

    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    logic [19:0] cdf_tb    [256];
    logic [11:0] model_lut [256];
    logic        model_valid = 1'b0;

    // expected mapping pipeline
    logic [11:0] s1_grey = '0, exp_grey = '0;
    logic        s1_dval = 1'b0, s1_fval = 1'b0, exp_dval = 1'b0, exp_fval = 1'b0;

    hist_equalizer dut (
        .iPclk      (iPclk),
        .iRST_N     (iRST_N),
        .iFval      (iFval),
        .iDval      (iDval),
        .iGrey      (iGrey),
        .iCdf_Valid (iCdf_Valid),
        .iCdf_Addr  (iCdf_Addr),
        .iCdf_Data  (iCdf_Data),
        .iCdf_Last  (iCdf_Last),
        .oCdf_Ready (oCdf_Ready),
        .oGrey_Eq   (oGrey_Eq),
        .oDval      (oDval),
        .oFval      (oFval),
        .oLut_Valid (oLut_Valid),
        .oLoad_Err  (oLoad_Err),
        .oState     (oState)
    );

    always #5 iPclk = ~iPclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output = f(input two cycles ago) using the model LUT
    always @(posedge iPclk or negedge iRST_N) begin
        if (!iRST_N) begin
            s1_grey <= '0; s1_dval <= 1'b0; s1_fval <= 1'b0;
            exp_grey <= '0; exp_dval <= 1'b0; exp_fval <= 1'b0;
        end else begin
            exp_grey <= !s1_dval ? 12'h000 : (model_valid ? model_lut[s1_grey[11:4]] : s1_grey);
            exp_dval <= s1_dval;
            exp_fval <= s1_fval;
            s1_grey  <= iGrey;
            s1_dval  <= iDval;
            s1_fval  <= iFval;
        end
    end

    always @(negedge iPclk) begin
        if (chk_en) begin
            check("stream_grey_eq", 32'(oGrey_Eq), 32'(exp_grey));
            check("stream_dval", 32'(oDval), 32'(exp_dval));
            check("stream_fval", 32'(oFval), 32'(exp_fval));
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iPclk);
            #1;
        end
    endtask

    task automatic load_cdf(input int n);
        for (int k = 0; k < n; k++) begin
            iCdf_Valid = 1'b1;
            iCdf_Addr  = 8'(k);
            iCdf_Data  = cdf_tb[k];
            iCdf_Last  = (k == n - 1);
            tick(1);
        end
        iCdf_Valid = 1'b0;
        iCdf_Last  = 1'b0;
    endtask

    // Equalisation rule in plain arithmetic
    task automatic build_model();
        longint mn, mx, v, c;
        mn = 64'h7FFF_FFFF;
        mx = longint'(cdf_tb[255]);
        for (int k = 0; k < 256; k++) begin
            c = longint'(cdf_tb[k]);
            if (c != 0 && c < mn) mn = c;
        end
        for (int k = 0; k < 256; k++) begin
            c = longint'(cdf_tb[k]);
            if (mx == mn)     v = k * 16 + k / 16;
            else if (c < mn)  v = 0;
            else              v = ((c - mn) * 4095) / (mx - mn);
            if (v > 4095) v = 4095;
            model_lut[k] = v[11:0];
        end
        model_valid = 1'b1;
    endtask

    task automatic pixel(input logic [11:0] g, input logic [11:0] exp, input string name);
        iFval = 1'b1;
        iDval = 1'b1;
        iGrey = g;
        tick(2);
        check(name, 32'(oGrey_Eq), 32'(exp));
    endtask

    task automatic frame_end();
        iDval = 1'b0;
        iFval = 1'b0;
        iGrey = '0;
        tick(4);
    endtask

    task automatic fill_uniform();
        for (int k = 0; k < 256; k++) cdf_tb[k] = 20'(100 * (k + 1));
    endtask

    initial begin
        iRST_N = 1'b1; iFval = 1'b1; iDval = 1'b0; iGrey = '0;
        iCdf_Valid = 1'b0; iCdf_Addr = '0; iCdf_Data = '0; iCdf_Last = 1'b0;
        #1 iRST_N = 1'b0;
        #1 chk_en = 1'b1;
        #1;
        check("rst_grey_eq", 32'(oGrey_Eq), 0);
        check("rst_dval", 32'(oDval), 0);
        check("rst_fval", 32'(oFval), 0);
        check("rst_lut_valid", 32'(oLut_Valid), 0);
        check("rst_load_err", 32'(oLoad_Err), 0);
        check("rst_state", 32'(oState), 0);
        check("rst_ready_in_frame", 32'(oCdf_Ready), 0);
        tick(3);
        iRST_N = 1'b1;
        iFval  = 1'b0;
        #1 check("ready_idle_blank", 32'(oCdf_Ready), 1);

        // bypass before any LUT exists
        pixel(12'h123, 12'h123, "bypass_123");
        check("bypass_lut_valid", 32'(oLut_Valid), 0);
        frame_end();

        // uniform CDF
        fill_uniform();
        load_cdf(256);
        check("uniform_enter_norm", 32'(oState), 2);
        check("ready_norm", 32'(oCdf_Ready), 0);
        tick(3900);
        check("uniform_done_state", 32'(oState), 0);
        check("uniform_lut_valid", 32'(oLut_Valid), 1);
        build_model();
        check("model_uniform_bin128", 32'(model_lut[128]), 2055);
        pixel(12'hFF0, 12'd4095, "uniform_ff0");
        pixel(12'h000, 12'd0, "uniform_000");
        pixel(12'h800, 12'd2055, "uniform_800");
        frame_end();

        // all counts in bin 40: flat range gives identity LUT
        for (int k = 0; k < 256; k++) cdf_tb[k] = (k < 40) ? 20'd0 : 20'd1000;
        load_cdf(256);
        tick(3900);
        check("flat_done_state", 32'(oState), 0);
        build_model();
        pixel(12'h5A0, 12'h5A5, "identity_5a0");
        pixel(12'hFF0, 12'hFFF, "identity_ff0");
        frame_end();

        // short load: error pulse, nothing swapped
        fill_uniform();
        load_cdf(200);
        check("short_err_pulse", 32'(oLoad_Err), 1);
        check("short_state_idle", 32'(oState), 0);
        tick(1);
        check("short_err_one_cycle", 32'(oLoad_Err), 0);
        check("short_lut_valid", 32'(oLut_Valid), 1);
        pixel(12'h5A0, 12'h5A5, "short_keeps_lut");
        frame_end();

        // frame start during NORM aborts; then a clean reload swaps
        load_cdf(256);
        tick(1000);
        check("abort_pre_state", 32'(oState), 2);
        iFval = 1'b1;
        tick(1);
        check("abort_state_idle", 32'(oState), 0);
        check("abort_no_err", 32'(oLoad_Err), 0);
        pixel(12'h5A0, 12'h5A5, "abort_keeps_lut");
        frame_end();
        load_cdf(256);
        tick(3900);
        check("reload_state", 32'(oState), 0);
        build_model();
        pixel(12'h800, 12'd2055, "reload_800");
        pixel(12'h5A0, 12'd1445, "reload_5a0");
        frame_end();

        // quadratic CDF with leading empty bins, full sweep through the compare process
        for (int k = 0; k < 256; k++) cdf_tb[k] = (k < 10) ? 20'd0 : 20'(3 * (k + 1) * (k + 1));
        load_cdf(256);
        tick(3900);
        build_model();
        check("model_quad_bin127", 32'(model_lut[127]), 1018);
        pixel(12'h7F0, 12'd1018, "quad_7f0");
        pixel(12'h050, 12'd0, "quad_050");
        pixel(12'hFF0, 12'd4095, "quad_ff0");
        for (int k = 0; k < 256; k++) begin
            iGrey = 12'((k << 4) | (k & 15));
            tick(1);
        end
        frame_end();

        // reset in the middle of NORM
        fill_uniform();
        load_cdf(256);
        tick(500);
        #2;
        iRST_N      = 1'b0;
        model_valid = 1'b0;
        #1;
        check("midrst_state", 32'(oState), 0);
        check("midrst_lut_valid", 32'(oLut_Valid), 0);
        check("midrst_grey_eq", 32'(oGrey_Eq), 0);
        check("midrst_load_err", 32'(oLoad_Err), 0);
        tick(3);
        iRST_N = 1'b1;
        pixel(12'hABC, 12'hABC, "post_rst_bypass_abc");
        pixel(12'h5A0, 12'h5A0, "post_rst_bypass_5a0");
        frame_end();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
